// File: rtl/piano_pkg.sv
`default_nettype none
// =============================================================================
// piano_pkg : note half-period table and key-to-divider helper.
// Rev 1.0
// =============================================================================
package piano_pkg;

   localparam int unsigned MIN_DIV = 2;

   // Octave-0 half-period counts at 1 MHz, C through B.
   localparam logic [15:0] NOTE_DIV [0:11] = '{
      16'd30581, 16'd28865, 16'd27245, 16'd25716, 16'd24272, 16'd22910,
      16'd21625, 16'd20411, 16'd19265, 16'd18182, 16'd17161, 16'd16198
   };

   function automatic logic [31:0] key_div(input logic [31:0] key, input logic [3:0] octave);
      logic [3:0]  note;
      logic [31:0] shift;
      logic [31:0] div;
      note  = 4'(key % 32'd12);
      shift = 32'(octave) + key / 32'd12;
      div   = 32'(NOTE_DIV[note]) >> shift;
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage
`default_nettype wire

// File: rtl/poly_piano_voices_if.sv
`default_nettype none
// =============================================================================
// poly_piano_voices_if : key/octave inputs and voice/audio outputs.
// Rev 1.0
// =============================================================================
interface poly_piano_voices_if #(
   parameter int NUM_KEYS   = 12,
   parameter int NUM_VOICES = 4
);
   localparam int MIX_W = $clog2(NUM_VOICES + 1);

   logic                  ena;
   logic [NUM_KEYS-1:0]   keys;
   logic [3:0]            octave;
   logic [NUM_VOICES-1:0] tone_out;
   logic [NUM_VOICES-1:0] voice_busy;
   logic [MIX_W-1:0]      mix_out;
   logic                  pwm_out;
   logic                  dropped;

   modport master (
      output ena, keys, octave,
      input  tone_out, voice_busy, mix_out, pwm_out, dropped
   );

   modport slave (
      input  ena, keys, octave,
      output tone_out, voice_busy, mix_out, pwm_out, dropped
   );
endinterface
`default_nettype wire

// File: rtl/piano_voice.sv
`default_nettype none
// =============================================================================
// piano_voice : one square-wave tone voice; optional age tracking (VOICE_STEAL_EN).
// Rev 1.0
// =============================================================================
module piano_voice
   import piano_pkg::*;
#(
   parameter int KEY_W         = 4,
   parameter int WIDTH_COUNTER = 16
`ifdef VOICE_STEAL_EN
   ,
   parameter int AGE_W         = 3
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             alloc_i,
   input  logic             free_i,
   input  logic [KEY_W-1:0] key_i,
   input  logic [3:0]       octave_i,
`ifdef VOICE_STEAL_EN
   input  logic             age_inc_i,
   output logic [AGE_W-1:0] age_o,
`endif
   output logic             busy_o,
   output logic [KEY_W-1:0] key_o,
   output logic             tone_o
);

   logic                     busy_q;
   logic [KEY_W-1:0]         key_q;
   logic [WIDTH_COUNTER-1:0] cnt_q;
   logic                     tone_q;
   logic [WIDTH_COUNTER-1:0] div;

   // Divider follows the live octave every cycle.
   assign div = WIDTH_COUNTER'(key_div(32'(key_q), octave_i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         key_q  <= '0;
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (clr_i) begin
         busy_q <= 1'b0;
         key_q  <= '0;
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (alloc_i) begin
         busy_q <= 1'b1;
         key_q  <= key_i;
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (free_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (busy_q) begin
         // >= lets a sudden divider decrease wrap on the next cycle.
         if (cnt_q >= div - WIDTH_COUNTER'(1)) begin
            cnt_q  <= '0;
            tone_q <= ~tone_q;
         end else begin
            cnt_q  <= cnt_q + WIDTH_COUNTER'(1);
         end
      end
   end

`ifdef VOICE_STEAL_EN
   logic [AGE_W-1:0] age_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else if (clr_i || alloc_i || free_i) begin
         age_q <= '0;
      end else if (age_inc_i && busy_q && (age_q != {AGE_W{1'b1}})) begin
         age_q <= age_q + AGE_W'(1);
      end
   end

   assign age_o = age_q;
`endif

   assign busy_o = busy_q;
   assign key_o  = key_q;
   assign tone_o = tone_q;

endmodule
`default_nettype wire

// File: rtl/poly_piano_voices.sv
`default_nettype none
// =============================================================================
// poly_piano_voices : key edge queue, voice allocator, tone mixer and PWM.
// Optional voice stealing when VOICE_STEAL_EN is defined.  Rev 1.0
// =============================================================================
module poly_piano_voices
   import piano_pkg::*;
#(
   parameter int NUM_KEYS      = 12,
   parameter int NUM_VOICES    = 4,
   parameter int WIDTH_COUNTER = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   poly_piano_voices_if.slave  bus
);

   localparam int KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int MIX_W   = $clog2(NUM_VOICES + 1);
   localparam int ACC_W   = $clog2(NUM_VOICES) + 1;

   logic [NUM_KEYS-1:0]   sync1_q, sync2_q, prev_q;
   logic [NUM_KEYS-1:0]   press_pend_q, press_pend_d;
   logic [NUM_KEYS-1:0]   rel_pend_q, rel_pend_d;
   logic [MIX_W-1:0]      mix_q, mix_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic                  pwm_q, pwm_d;
   logic                  dropped_q, dropped_d;

   logic [NUM_KEYS-1:0]   press_edge, rel_edge, press_clr, rel_clr;
   logic                  rel_hit, press_hit, svc_press, free_hit;
   logic [KEY_W-1:0]      rel_idx, press_idx;
   logic [VOICE_W-1:0]    free_idx;
   logic [NUM_VOICES-1:0] alloc, free, busy_vec, tone_vec;
   logic [KEY_W-1:0]      vkey [NUM_VOICES];
   logic [ACC_W:0]        sum;

   assign press_edge = sync2_q & ~prev_q;
   assign rel_edge   = ~sync2_q & prev_q;

`ifdef VOICE_STEAL_EN
   localparam int AGE_W = $clog2(NUM_VOICES) + 1;
   logic [AGE_W-1:0]   vage [NUM_VOICES];
   logic [AGE_W-1:0]   oldest_age;
   logic [VOICE_W-1:0] oldest_idx;

   // Strict > keeps the lowest index on ties.
   always_comb begin
      oldest_age = vage[0];
      oldest_idx = '0;
      for (int v = 1; v < NUM_VOICES; v++) begin
         if (vage[v] > oldest_age) begin
            oldest_age = vage[v];
            oldest_idx = VOICE_W'(v);
         end
      end
   end
`endif

   always_comb begin
      rel_hit   = 1'b0;
      rel_idx   = '0;
      press_hit = 1'b0;
      press_idx = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (rel_pend_q[k]) begin
            rel_hit = 1'b1;
            rel_idx = KEY_W'(k);
         end
         if (press_pend_q[k]) begin
            press_hit = 1'b1;
            press_idx = KEY_W'(k);
         end
      end

      free_hit = 1'b0;
      free_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!busy_vec[v]) begin
            free_hit = 1'b1;
            free_idx = VOICE_W'(v);
         end
      end

      // Releases take priority; at most one event serviced per cycle.
      svc_press = press_hit && !rel_hit;
      for (int k = 0; k < NUM_KEYS; k++) begin
         rel_clr[k]   = rel_hit && (rel_idx == KEY_W'(k));
         press_clr[k] = svc_press && (press_idx == KEY_W'(k));
      end

      dropped_d = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         free[v]  = rel_hit && busy_vec[v] && (vkey[v] == rel_idx);
         alloc[v] = svc_press && free_hit && (free_idx == VOICE_W'(v));
`ifdef VOICE_STEAL_EN
         if (svc_press && !free_hit && (oldest_idx == VOICE_W'(v))) begin
            alloc[v] = 1'b1;
         end
`endif
      end
`ifndef VOICE_STEAL_EN
      dropped_d = svc_press && !free_hit;
`endif

      // A fresh edge on a bit being serviced keeps the bit set.
      press_pend_d = (press_pend_q & ~press_clr) | press_edge;
      rel_pend_d   = (rel_pend_q & ~rel_clr) | rel_edge;

      mix_d = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         mix_d = mix_d + MIX_W'(tone_vec[v]);
      end

      sum = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(mix_q);
      if (sum >= (ACC_W + 1)'(NUM_VOICES)) begin
         pwm_d = 1'b1;
         acc_d = ACC_W'(sum - (ACC_W + 1)'(NUM_VOICES));
      end else begin
         pwm_d = 1'b0;
         acc_d = ACC_W'(sum);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         prev_q       <= '0;
         press_pend_q <= '0;
         rel_pend_q   <= '0;
         mix_q        <= '0;
         acc_q        <= '0;
         pwm_q        <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         // Synchronisers run regardless of enable so held keys are not re-triggered.
         sync1_q <= bus.keys;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         if (!bus.ena) begin
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            mix_q        <= '0;
            acc_q        <= '0;
            pwm_q        <= 1'b0;
            dropped_q    <= 1'b0;
         end else begin
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            mix_q        <= mix_d;
            acc_q        <= acc_d;
            pwm_q        <= pwm_d;
            dropped_q    <= dropped_d;
         end
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
`ifdef VOICE_STEAL_EN
      piano_voice #(
         .KEY_W         (KEY_W),
         .WIDTH_COUNTER (WIDTH_COUNTER),
         .AGE_W         (AGE_W)
      ) u_voice (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr_i     (!bus.ena),
         .alloc_i   (alloc[v]),
         .free_i    (free[v]),
         .key_i     (press_idx),
         .octave_i  (bus.octave),
         .age_inc_i (|alloc),
         .age_o     (vage[v]),
         .busy_o    (busy_vec[v]),
         .key_o     (vkey[v]),
         .tone_o    (tone_vec[v])
      );
`else
      piano_voice #(
         .KEY_W         (KEY_W),
         .WIDTH_COUNTER (WIDTH_COUNTER)
      ) u_voice (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr_i    (!bus.ena),
         .alloc_i  (alloc[v]),
         .free_i   (free[v]),
         .key_i    (press_idx),
         .octave_i (bus.octave),
         .busy_o   (busy_vec[v]),
         .key_o    (vkey[v]),
         .tone_o   (tone_vec[v])
      );
`endif
   end

   assign bus.tone_out   = tone_vec;
   assign bus.voice_busy = busy_vec;
   assign bus.mix_out    = mix_q;
   assign bus.pwm_out    = pwm_q;
   assign bus.dropped    = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_piano_voices.sv
`default_nettype none
// =============================================================================
// tb_poly_piano_voices : directed stimulus with a cycle-stamped scoreboard.
// Rev 1.0
// =============================================================================
module tb_poly_piano_voices;

   localparam int NK = 12;
   localparam int NV = 4;
   localparam logic [31:0] ALL = 32'hFFFF_FFFF;
`ifdef VOICE_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif

   localparam int S_TONE = 0, S_BUSY = 1, S_MIX = 2, S_PWM = 3, S_DROP = 4, S_PWM4 = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   poly_piano_voices_if #(.NUM_KEYS(NK), .NUM_VOICES(NV)) bus ();

   poly_piano_voices #(
      .NUM_KEYS      (NK),
      .NUM_VOICES    (NV),
      .WIDTH_COUNTER (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      int          at;
      int          sel;
      logic [31:0] mask;
      logic [31:0] exp;
   } chk_t;

   chk_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  pwm_hist = '0;

   function automatic void expect_at(string name, int at, int sel, logic [31:0] mask, logic [31:0] exp);
      chk_t c;
      int   i;
      c.name = name; c.at = at; c.sel = sel; c.mask = mask; c.exp = exp;
      i = sb.size();
      while (i > 0 && sb[i-1].at > at) i--;
      sb.insert(i, c);
   endfunction

   function automatic logic [31:0] observe(int sel);
      case (sel)
         S_TONE:  return 32'(bus.tone_out);
         S_BUSY:  return 32'(bus.voice_busy);
         S_MIX:   return 32'(bus.mix_out);
         S_PWM:   return 32'(bus.pwm_out);
         S_DROP:  return 32'(bus.dropped);
         S_PWM4:  return 32'($countones(pwm_hist));
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: samples on the falling edge and retires every check due this cycle.
   initial begin
      chk_t        c;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         pwm_hist = {pwm_hist[2:0], bus.pwm_out};
         while (sb.size() > 0 && sb[0].at <= cyc) begin
            c   = sb.pop_front();
            act = observe(c.sel) & c.mask;
            n_vec++;
            if (c.at < cyc) begin
               n_err++;
               $display("FAIL %s: due at cycle %0d, sampled at %0d, got %0h, expected %0h",
                        c.name, c.at, cyc, act, c.exp & c.mask);
            end else if (act !== (c.exp & c.mask)) begin
               n_err++;
               $display("FAIL %s @%0d: got %0h, expected %0h", c.name, cyc, act, c.exp & c.mask);
            end
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int t;
      bus.ena    = 1'b0;
      bus.keys   = '0;
      bus.octave = 4'd4;
      rst_n      = 1'b0;
      step(3);
      rst_n   = 1'b1;
      bus.ena = 1'b1;
      step(2);
      t = cyc;
      expect_at("rst_tone",  t + 1, S_TONE, ALL, 0);
      expect_at("rst_busy",  t + 1, S_BUSY, ALL, 0);
      expect_at("rst_mix",   t + 1, S_MIX,  ALL, 0);
      expect_at("rst_pwm",   t + 1, S_PWM,  ALL, 0);
      expect_at("rst_drop",  t + 1, S_DROP, ALL, 0);
      step(3);

      // Key 9 (A) at octave 4: half period 18182>>4 = 1136.
      bus.keys = 12'h200;
      t = cyc;
      expect_at("a4_busy_early", t + 3,    S_BUSY, ALL, 4'b0000);
      expect_at("a4_busy",       t + 4,    S_BUSY, ALL, 4'b0001);
      expect_at("a4_tone_pre",   t + 1139, S_TONE, 1,   0);
      expect_at("a4_tone_rise",  t + 1140, S_TONE, 1,   1);
      expect_at("a4_mix_pre",    t + 1140, S_MIX,  ALL, 0);
      expect_at("a4_mix_rise",   t + 1141, S_MIX,  ALL, 1);
      expect_at("a4_tone_hi",    t + 2275, S_TONE, 1,   1);
      expect_at("a4_tone_fall",  t + 2276, S_TONE, 1,   0);
      expect_at("a4_tone_rise2", t + 3412, S_TONE, 1,   1);
      step(3420);
      bus.keys = '0;
      t = cyc;
      expect_at("a4_rel_held", t + 3, S_BUSY, ALL, 4'b0001);
      expect_at("a4_rel_busy", t + 4, S_BUSY, ALL, 4'b0000);
      expect_at("a4_rel_tone", t + 4, S_TONE, ALL, 4'b0000);
      step(10);

      // Five simultaneous presses on four voices.
      bus.keys = 12'h01F;
      t = cyc;
      expect_at("alloc_v0",   t + 4, S_BUSY, ALL, 4'b0001);
      expect_at("alloc_v1",   t + 5, S_BUSY, ALL, 4'b0011);
      expect_at("alloc_v2",   t + 6, S_BUSY, ALL, 4'b0111);
      expect_at("alloc_v3",   t + 7, S_BUSY, ALL, 4'b1111);
      expect_at("drop_pre",   t + 7, S_DROP, ALL, 0);
      expect_at("drop_pulse", t + 8, S_DROP, ALL, STEAL ? 0 : 1);
      expect_at("drop_post",  t + 9, S_DROP, ALL, 0);
      expect_at("v1_tone_pre",  t + 1808, S_TONE, 2, 0);
      expect_at("v1_tone_rise", t + 1809, S_TONE, 2, 2);
      // Voice 0 plays key 0 (div 1911 from edge 4) or, if stolen, key 4 (div 1517 from edge 8).
      expect_at("v0_tone_pre",  STEAL ? t + 1524 : t + 1914, S_TONE, 1, 0);
      expect_at("v0_tone_rise", STEAL ? t + 1525 : t + 1915, S_TONE, 1, 1);
      step(1930);
      bus.keys = '0;
      t = cyc;
      expect_at("rel_key0", t + 4, S_BUSY, ALL, STEAL ? 4'b1111 : 4'b1110);
      expect_at("rel_key3", t + 7, S_BUSY, ALL, STEAL ? 4'b0001 : 4'b0000);
      expect_at("rel_key4", t + 8, S_BUSY, ALL, 4'b0000);
      step(12);

      // Live octave change 0 -> 8 on key 0: div 30581 -> 119.
      bus.octave = 4'd0;
      bus.keys   = 12'h001;
      t = cyc;
      expect_at("oct_busy", t + 4, S_BUSY, ALL, 4'b0001);
      step(204);
      bus.octave = 4'd8;
      t = cyc;
      expect_at("oct_tone_lo",   t,       S_TONE, 1, 0);
      expect_at("oct_wrap",      t + 1,   S_TONE, 1, 1);
      expect_at("oct_tone_hi",   t + 119, S_TONE, 1, 1);
      expect_at("oct_tone_fall", t + 120, S_TONE, 1, 0);
      step(125);
      bus.keys   = '0;
      bus.octave = 4'd4;
      step(10);

      // Keys 0,1,2 at octave 4: all three high from +1915 to +3409.
      bus.keys = 12'h007;
      t = cyc;
      expect_at("mix1",       t + 1780, S_MIX,  ALL, 1);
      expect_at("pwm_duty14", t + 1780, S_PWM4, ALL, 1);
      expect_at("mix1b",      t + 1800, S_MIX,  ALL, 1);
      expect_at("mix2",       t + 1850, S_MIX,  ALL, 2);
      expect_at("mix3",       t + 2000, S_MIX,  ALL, 3);
      expect_at("tone3",      t + 2000, S_TONE, ALL, 4'b0111);
      expect_at("pwm_duty34", t + 2003, S_PWM4, ALL, 3);
      expect_at("pwm_duty34b",t + 2101, S_PWM4, ALL, 3);
      step(2110);
      bus.keys = '0;
      step(10);

      // Asynchronous reset mid-note.
      bus.keys = 12'h200;
      step(1200);
      t = cyc;
      expect_at("prerst_tone", t, S_TONE, 1, 1);
      expect_at("prerst_busy", t, S_BUSY, 1, 1);
      step(1);
      rst_n = 1'b0;
      t = cyc;
      expect_at("arst_tone", t, S_TONE, ALL, 0);
      expect_at("arst_busy", t, S_BUSY, ALL, 0);
      expect_at("arst_mix",  t, S_MIX,  ALL, 0);
      expect_at("arst_pwm",  t, S_PWM,  ALL, 0);
      bus.keys = '0;
      step(3);
      rst_n = 1'b1;
      step(3);

      // Synchronous disable with the key held throughout.
      bus.keys = 12'h200;
      step(10);
      bus.ena = 1'b0;
      t = cyc;
      expect_at("ena_busy_hold", t,     S_BUSY, ALL, 4'b0001);
      expect_at("ena_busy_clr",  t + 1, S_BUSY, ALL, 4'b0000);
      expect_at("ena_tone_clr",  t + 1, S_TONE, ALL, 4'b0000);
      step(10);
      bus.ena = 1'b1;
      t = cyc;
      expect_at("reena_busy", t + 6, S_BUSY, ALL, 4'b0000);
      expect_at("reena_drop", t + 6, S_DROP, ALL, 0);
      step(10);
      bus.keys = '0;
      t = cyc;
      expect_at("orphan_rel", t + 6, S_BUSY, ALL, 4'b0000);
      step(10);

      for (int i = 0; i < 5000 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d checks still pending, required 0", sb.size());
         n_err += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
